rr_exe_pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the RR→EXE pipeline latch. It generates the latch's `LOCK`, `FLUSH_P1` and `FLUSH_P2` controls, and a front-end stall. It holds multi-cycle operations (MUL/DIV, data-memory misses) in EXE, drains the pipe after branch mispredicts and exceptions, and parks the pipe on debug halt. It sits beside the RR→EXE latch and drives that latch's control inputs directly; it also exports a stall performance counter.

---
 rtl/rr_exe_ctrl_pkg.sv | 19 +
 rtl/rr_exe_lat_cnt.sv | 36 +++
 rtl/rr_exe_pipe_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rr_exe_pipe_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_exe_ctrl_pkg.sv
// Shared encodings for the RR->EXE pipeline sequencing controller.
package rr_exe_ctrl_pkg;

    localparam int CNT_W = 6;

    localparam logic [1:0] CLS_SINGLE = 2'b00;
    localparam logic [1:0] CLS_MUL    = 2'b01;
    localparam logic [1:0] CLS_DIV    = 2'b10;
    localparam logic [1:0] CLS_MEM    = 2'b11;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_MULTI,
        ST_MEMW,
        ST_DRAIN,
        ST_HALT
    } state_e;

endpackage

// File: rtl/rr_exe_lat_cnt.sv
// Loadable down-counter with zero flag; stops at zero, load wins over decrement.
module rr_exe_lat_cnt
    import rr_exe_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/rr_exe_pipe_ctrl.sv
// Sequencing controller for the RR->EXE latch: lock, flush and front-end stall.
//   state | meaning
//   RUN   | normal issue, decide lock/flush/halt for the op in EXE
//   MULTI | MUL/DIV holding EXE, cnt = remaining lock cycles
//   MEMW  | MEM op waiting on the data cache
//   DRAIN | bubbling the latch after a mispredict or exception
//   HALT  | parked for debug
module rr_exe_pipe_ctrl
    import rr_exe_ctrl_pkg::*;
#(
    parameter int MUL_LAT     = 3,
    parameter int DIV_LAT     = 34,
    parameter int FLUSH_DRAIN = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ISSUE_VALID,
    input  logic [1:0]  ISSUE_CLASS,
    input  logic        MEM_READY,
    input  logic        BRANCH_MISS,
    input  logic        XCPT,
    input  logic        DEBUG_HALT,
    output logic        LOCK,
    output logic        FLUSH_P1,
    output logic        FLUSH_P2,
    output logic        FE_STALL,
    output logic [5:0]  BUSY_CNT,
    output logic [31:0] STALL_CYCLES
);

    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(FLUSH_DRAIN - 1);

    state_e           state_d, state_q;
    logic             lock, flush_p1, flush_p2;
    logic             is_multi, is_mem;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val, cnt;
    logic             drain_load, drain_dec, drain_zero;
    logic [CNT_W-1:0] drain;
    logic [31:0]      stall_cycles_d, stall_cycles_q;

    always_comb begin
        state_d      = state_q;
        lock         = 1'b0;
        flush_p1     = 1'b0;
        flush_p2     = 1'b0;
        is_multi     = 1'b0;
        is_mem       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        drain_load   = 1'b0;
        drain_dec    = 1'b0;

        case (ISSUE_CLASS)
            CLS_MUL, CLS_DIV: is_multi = ISSUE_VALID;
            CLS_MEM:          is_mem   = ISSUE_VALID;
            CLS_SINGLE:       ;
            default:          ;
        endcase

        if (XCPT) begin
            flush_p1   = 1'b1;
            cnt_load   = 1'b1;
            drain_load = 1'b1;
            state_d    = (DRAIN_LOAD != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (is_multi) begin
                        lock         = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = (ISSUE_CLASS == CLS_MUL) ? MUL_LOAD : DIV_LOAD;
                        state_d      = ST_MULTI;
                    end else if (is_mem && !MEM_READY) begin
                        lock    = 1'b1;
                        state_d = ST_MEMW;
                    end else if (BRANCH_MISS) begin
                        flush_p2   = 1'b1;
                        drain_load = 1'b1;
                        state_d    = (DRAIN_LOAD != '0) ? ST_DRAIN : ST_RUN;
                    end else if (DEBUG_HALT) begin
                        state_d = ST_HALT;
                    end
                end
                ST_MULTI: begin
                    if (!cnt_zero) begin
                        lock    = 1'b1;
                        cnt_dec = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEMW: begin
                    lock = !MEM_READY;
                    if (MEM_READY) state_d = ST_RUN;
                end
                // drain holds the number of flush cycles still owed, this one included
                ST_DRAIN: begin
                    flush_p2  = 1'b1;
                    drain_dec = 1'b1;
                    if (drain_zero || (drain == CNT_W'(1))) state_d = ST_RUN;
                end
                ST_HALT: begin
                    lock = DEBUG_HALT;
                    if (!DEBUG_HALT) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end

        if (!RST) begin
            lock     = 1'b0;
            flush_p1 = 1'b0;
            flush_p2 = 1'b0;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (lock && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q        <= ST_RUN;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    rr_exe_lat_cnt u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    rr_exe_lat_cnt u_drain (
        .CLK      (CLK),
        .RST      (RST),
        .load     (drain_load),
        .load_val (DRAIN_LOAD),
        .dec      (drain_dec),
        .count    (drain),
        .zero     (drain_zero)
    );

    assign LOCK         = lock;
    assign FLUSH_P1     = flush_p1;
    assign FLUSH_P2     = flush_p2;
    assign FE_STALL     = lock | flush_p1 | flush_p2;
    assign BUSY_CNT     = (RST && (state_q == ST_MULTI)) ? cnt : '0;
    assign STALL_CYCLES = stall_cycles_q;

endmodule

// File: tb/tb_rr_exe_pipe_ctrl.sv
// Bench for rr_exe_pipe_ctrl: occupancy-based reference model plus directed pins and random traffic.
module tb_rr_exe_pipe_ctrl;
    import rr_exe_ctrl_pkg::*;

    localparam int MUL_LAT     = 3;
    localparam int DIV_LAT     = 34;
    localparam int FLUSH_DRAIN = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ISSUE_VALID = 1'b0;
    logic [1:0]  ISSUE_CLASS = 2'b00;
    logic        MEM_READY = 1'b0;
    logic        BRANCH_MISS = 1'b0;
    logic        XCPT = 1'b0;
    logic        DEBUG_HALT = 1'b0;
    logic        LOCK, FLUSH_P1, FLUSH_P2, FE_STALL;
    logic [5:0]  BUSY_CNT;
    logic [31:0] STALL_CYCLES;

    always #5 CLK = ~CLK;

    rr_exe_pipe_ctrl #(
        .MUL_LAT     (MUL_LAT),
        .DIV_LAT     (DIV_LAT),
        .FLUSH_DRAIN (FLUSH_DRAIN)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ISSUE_VALID  (ISSUE_VALID),
        .ISSUE_CLASS  (ISSUE_CLASS),
        .MEM_READY    (MEM_READY),
        .BRANCH_MISS  (BRANCH_MISS),
        .XCPT         (XCPT),
        .DEBUG_HALT   (DEBUG_HALT),
        .LOCK         (LOCK),
        .FLUSH_P1     (FLUSH_P1),
        .FLUSH_P2     (FLUSH_P2),
        .FE_STALL     (FE_STALL),
        .BUSY_CNT     (BUSY_CNT),
        .STALL_CYCLES (STALL_CYCLES)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: cycles of EXE occupancy left for a MUL/DIV, pending cache wait,
    // owed flush cycles, debug park, and the stall tally.
    int              m_op_left = 0;
    bit              m_mem = 0;
    int              m_flush_left = 0;
    bit              m_halt = 0;
    longint unsigned m_stall = 0;
    bit              m_stall_known = 0;

    logic        o_lock, o_fp1, o_fp2, o_fe;
    logic [5:0]  o_busy;
    logic [31:0] o_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic valid, input logic [1:0] cls,
                        input logic rdy, input logic bm, input logic xc, input logic dh);
        logic e_lock, e_fp1, e_fp2;
        int e_busy;
        longint unsigned e_stall;
        @(posedge CLK);
        #1;
        RST = rst; ISSUE_VALID = valid; ISSUE_CLASS = cls; MEM_READY = rdy;
        BRANCH_MISS = bm; XCPT = xc; DEBUG_HALT = dh;
        @(negedge CLK);
        e_lock = 0; e_fp1 = 0; e_fp2 = 0; e_busy = 0; e_stall = m_stall;
        if (!rst) begin
            m_op_left = 0; m_mem = 0; m_halt = 0; m_flush_left = 0;
        end else if (xc) begin
            e_fp1 = 1;
            if (m_op_left > 0) e_busy = m_op_left - 1;
            m_op_left = 0; m_mem = 0; m_halt = 0; m_flush_left = FLUSH_DRAIN - 1;
        end else if (m_op_left > 0) begin
            e_busy = m_op_left - 1;
            e_lock = (m_op_left > 1);
            m_op_left--;
        end else if (m_mem) begin
            e_lock = !rdy;
            if (rdy) m_mem = 0;
        end else if (m_flush_left > 0) begin
            e_fp2 = 1;
            m_flush_left--;
        end else if (m_halt) begin
            e_lock = dh;
            if (!dh) m_halt = 0;
        end else if (valid && (cls == CLS_MUL || cls == CLS_DIV)) begin
            e_lock = 1;
            m_op_left = ((cls == CLS_MUL) ? MUL_LAT : DIV_LAT) - 1;
        end else if (valid && cls == CLS_MEM && !rdy) begin
            e_lock = 1;
            m_mem = 1;
        end else if (bm) begin
            e_fp2 = 1;
            m_flush_left = FLUSH_DRAIN - 1;
        end else if (dh) begin
            m_halt = 1;
        end

        chk("LOCK", LOCK, e_lock);
        chk("FLUSH_P1", FLUSH_P1, e_fp1);
        chk("FLUSH_P2", FLUSH_P2, e_fp2);
        chk("FE_STALL", FE_STALL, e_lock | e_fp1 | e_fp2);
        chk("BUSY_CNT", BUSY_CNT, e_busy);
        if (m_stall_known) chk("STALL_CYCLES", STALL_CYCLES, e_stall);

        if (!rst) begin
            m_stall = 0;
            m_stall_known = 1;
        end else if (e_lock && m_stall != 64'hFFFF_FFFF) begin
            m_stall++;
        end
        o_lock = LOCK; o_fp1 = FLUSH_P1; o_fp2 = FLUSH_P2; o_fe = FE_STALL;
        o_busy = BUSY_CNT; o_stall = STALL_CYCLES;
    endtask

    task automatic idle(input logic dh);
        step(1, 0, CLS_SINGLE, 1, 0, 0, dh);
    endtask

    initial begin
        int n;
        logic r_rst, r_v, r_rdy, r_bm, r_xc, r_dh;
        logic [1:0] r_c;

        // reset
        step(0, 0, CLS_SINGLE, 0, 0, 0, 0);
        chk("rst_lock", o_lock, 0);
        step(0, 1, CLS_MUL, 0, 1, 1, 1);
        chk("rst_fe", o_fe, 0);
        chk("rst_stall", o_stall, 0);
        idle(0);

        // MUL: lock 1,1,0 and busy 1,0
        step(1, 1, CLS_MUL, 1, 0, 0, 0);
        chk("mul_lock0", o_lock, 1);
        idle(0);
        chk("mul_lock1", o_lock, 1);
        chk("mul_busy1", o_busy, 1);
        idle(0);
        chk("mul_lock2", o_lock, 0);
        chk("mul_busy2", o_busy, 0);
        idle(0);
        chk("mul_stall", o_stall, 2);

        // DIV: 33 lock cycles, busy starts at 32
        step(1, 1, CLS_DIV, 1, 0, 0, 0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            idle(0);
            if (i == 0) chk("div_busy_first", o_busy, 32);
            if (o_lock) n++;
            else break;
        end
        chk("div_lock_cycles", n, 33);
        idle(0);
        chk("div_back_run", o_lock, 0);

        // MEM miss for 5 cycles
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, CLS_MEM, 0, 0, 0, 0);
            if (o_lock) n++;
        end
        chk("mem_lock_cycles", n, 5);
        step(1, 1, CLS_MEM, 1, 0, 0, 0);
        chk("mem_ready_lock", o_lock, 0);
        idle(0);

        // XCPT in the 10th DIV cycle
        step(1, 1, CLS_DIV, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) idle(0);
        step(1, 0, CLS_SINGLE, 1, 0, 1, 0);
        chk("xcpt_fp1", o_fp1, 1);
        chk("xcpt_lock", o_lock, 0);
        idle(0);
        chk("xcpt_drain_fp2", o_fp2, 1);
        idle(0);
        chk("xcpt_done_fe", o_fe, 0);

        // branch mispredict drain
        step(1, 0, CLS_SINGLE, 1, 1, 0, 0);
        chk("bm_fp2_0", o_fp2, 1);
        idle(0);
        chk("bm_fe_1", o_fe, 1);
        idle(0);
        chk("bm_fe_2", o_fe, 0);

        // debug halt deferred behind a MUL
        step(1, 1, CLS_MUL, 1, 0, 0, 1);
        idle(1);
        idle(1);
        chk("halt_mul_done", o_busy, 0);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("halt_lock", o_lock, 1);
        end
        idle(0);
        chk("halt_release", o_lock, 0);

        // reset in the middle of a DIV
        step(1, 1, CLS_DIV, 1, 0, 0, 0);
        idle(0);
        idle(0);
        step(0, 0, CLS_SINGLE, 1, 0, 0, 0);
        chk("midrst_lock", o_lock, 0);
        chk("midrst_busy", o_busy, 0);
        idle(0);
        chk("postrst_lock", o_lock, 0);
        chk("postrst_stall", o_stall, 0);

        // random traffic
        r_dh = 0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 299) != 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_c   = 2'($urandom_range(0, 3));
            r_rdy = ($urandom_range(0, 2) != 0);
            r_xc  = ($urandom_range(0, 39) == 0);
            r_bm  = (!r_v || r_c == CLS_SINGLE) && ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) r_dh = !r_dh;
            step(r_rst, r_v, r_c, r_rdy, r_bm, r_xc, r_dh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
